// File: rtl/csr_master_arbiter_pkg.sv
// Shared CSR bus request/response types and the arbiter state encoding.
// Imported by csr_master_arbiter and csr_arbiter_timer.
package csr_master_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic        read_not_write;
        logic [15:0] select;
        logic [15:0] address;
        logic [31:0] data;
    } t_csr_request;

    typedef struct packed {
        logic        acknowledge;
        logic        read_data_valid;
        logic        read_data_error;
        logic [31:0] read_data;
    } t_csr_response;

    // Kept as plain constants so older tools that dislike enum ports still parse it.
    typedef logic [1:0] t_csr_arbiter_state;
    localparam t_csr_arbiter_state ST_IDLE  = 2'd0;
    localparam t_csr_arbiter_state ST_REQ   = 2'd1;
    localparam t_csr_arbiter_state ST_RDATA = 2'd2;

    localparam int CSR_ARBITER_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/csr_master_arbiter_timer.sv
// Outstanding-transaction watchdog for csr_master_arbiter.
// Only instantiated when CSR_MASTER_ARBITER_TIMEOUT_EN is defined.
module csr_arbiter_timer
    import csr_master_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = CSR_ARBITER_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [7:0] LP_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] r_count;

    // Saturates so a limit of 255 cannot wrap back to zero and be missed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_expired = i_enable && (r_count == LP_LIMIT);

endmodule

// File: rtl/csr_master_arbiter.sv
// Two-master round-robin arbiter for the shared CSR target chain.
// Optional watchdog: define CSR_MASTER_ARBITER_TIMEOUT_EN.
module csr_master_arbiter
    import csr_master_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = CSR_ARBITER_TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  t_csr_request  req0,
    output t_csr_response resp0,
    input  t_csr_request  req1,
    output t_csr_response resp1,
    output t_csr_request  csr_request,
    input  t_csr_response csr_response,
    output logic [1:0]    grant,
    output logic          timeout_event
);

    t_csr_arbiter_state r_state;
    t_csr_request       r_csr_request;
    logic [1:0]         r_grant;
    logic               r_last_grant;
    logic [1:0]         r_pending;

    logic               w_any_valid;
    logic               w_winner;
    logic               w_expired;
    t_csr_response      w_resp;

    assign w_any_valid = req0.valid | req1.valid;
    // On contention the master that did not win last time goes next.
    assign w_winner    = (req0.valid && req1.valid) ? ~r_last_grant : ~req0.valid;

`ifdef CSR_MASTER_ARBITER_TIMEOUT_EN
    csr_arbiter_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clear  (r_state == ST_IDLE),
        .i_enable (r_state != ST_IDLE),
        .o_expired(w_expired)
    );
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_expired        = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_csr_request <= '0;
            r_grant       <= 2'b00;
            r_last_grant  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_valid) begin
                        r_csr_request <= w_winner ? req1 : req0;
                        r_grant       <= w_winner ? 2'b10 : 2'b01;
                        r_last_grant  <= w_winner;
                        r_state       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (w_expired) begin
                        r_csr_request <= '0;
                        r_grant       <= 2'b00;
                        r_state       <= ST_IDLE;
                    end else if (csr_response.acknowledge) begin
                        if (!r_csr_request.read_not_write || csr_response.read_data_valid) begin
                            r_csr_request <= '0;
                            r_grant       <= 2'b00;
                            r_state       <= ST_IDLE;
                        end else begin
                            r_csr_request.valid <= 1'b0;
                            r_state             <= ST_RDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    if (w_expired || csr_response.read_data_valid) begin
                        r_csr_request <= '0;
                        r_grant       <= 2'b00;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_csr_request <= '0;
                    r_grant       <= 2'b00;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    // A forced completion replaces whatever the target drives that cycle.
    always_comb begin
        w_resp = csr_response;
        if (w_expired) begin
            w_resp             = '0;
            w_resp.acknowledge = (r_state == ST_REQ);
            if (r_csr_request.read_not_write) begin
                w_resp.read_data_valid = 1'b1;
                w_resp.read_data_error = 1'b1;
            end
        end
        resp0 = '0;
        resp1 = '0;
        if (r_state != ST_IDLE) begin
            if (r_grant[0]) resp0 = w_resp;
            if (r_grant[1]) resp1 = w_resp;
        end
    end

    assign csr_request   = r_csr_request;
    assign grant         = r_grant;
    assign timeout_event = w_expired;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= 2'b00;
        end else begin
            r_pending <= {req1.valid && !resp1.acknowledge, req0.valid && !resp0.acknowledge};
        end
    end

    // A master must keep valid raised until it has been acknowledged.
    always @(posedge clk) begin
        if (reset_n) begin
            a_hold_req0: assert (!r_pending[0] || req0.valid);
            a_hold_req1: assert (!r_pending[1] || req1.valid);
        end
    end

endmodule

// File: tb/tb_csr_master_arbiter.sv
// Directed self-checking bench for csr_master_arbiter.
// The watchdog section runs only when CSR_MASTER_ARBITER_TIMEOUT_EN is defined.
module tb_csr_master_arbiter;
    import csr_master_arbiter_pkg::*;

    localparam t_csr_request  REQ_NONE = '0;
    localparam t_csr_request  W0 = {1'b1, 1'b0, 16'h0001, 16'h0010, 32'hDEADBEEF};
    localparam t_csr_request  W1 = {1'b1, 1'b0, 16'h0002, 16'h0020, 32'h0BADF00D};
    localparam t_csr_request  R0 = {1'b1, 1'b1, 16'h0001, 16'h0080, 32'h00000000};
    localparam t_csr_request  R1 = {1'b1, 1'b1, 16'h0004, 16'h0040, 32'h00000000};
    localparam t_csr_response RSP_NONE = '0;
    localparam t_csr_response RSP_ACK  = {1'b1, 1'b0, 1'b0, 32'h00000000};
    localparam t_csr_response RSP_RDV  = {1'b0, 1'b1, 1'b0, 32'h12345678};
    localparam t_csr_response RSP_TOUT = {1'b1, 1'b1, 1'b1, 32'h00000000};

    logic          clk;
    logic          reset_n;
    t_csr_request  req0;
    t_csr_request  req1;
    t_csr_response resp0;
    t_csr_response resp1;
    t_csr_request  csr_request;
    t_csr_response csr_response;
    logic [1:0]    grant;
    logic          timeout_event;

    int vectorCount = 0;
    int missCount   = 0;

    csr_master_arbiter #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req0         (req0),
        .resp0        (resp0),
        .req1         (req1),
        .resp1        (resp1),
        .csr_request  (csr_request),
        .csr_response (csr_response),
        .grant        (grant),
        .timeout_event(timeout_event)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [65:0] actual, input logic [65:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // One cycle: inputs change at the falling edge, outputs are checked just after.
    task automatic applyStimulus(input t_csr_request r0, input t_csr_request r1, input t_csr_response rsp);
        @(negedge clk);
        req0         = r0;
        req1         = r1;
        csr_response = rsp;
        #1;
    endtask

    task automatic writeTx(input t_csr_request a0, input t_csr_request a1,
                           input t_csr_request b0, input t_csr_request b1,
                           input logic [1:0] expGrant, input string tag);
        t_csr_request  expReq;
        t_csr_response exp0;
        t_csr_response exp1;
        expReq = expGrant[0] ? b0 : b1;
        exp0   = expGrant[0] ? RSP_ACK : RSP_NONE;
        exp1   = expGrant[1] ? RSP_ACK : RSP_NONE;
        applyStimulus(a0, a1, RSP_NONE);
        checkOutput({tag, "_idle_grant"}, grant, 2'b00);
        applyStimulus(b0, b1, RSP_NONE);
        checkOutput({tag, "_grant"}, grant, expGrant);
        checkOutput({tag, "_csr_req"}, csr_request, expReq);
        applyStimulus(b0, b1, RSP_ACK);
        checkOutput({tag, "_resp0"}, resp0, exp0);
        checkOutput({tag, "_resp1"}, resp1, exp1);
    endtask

    initial begin
        reset_n      = 1'b0;
        req0         = REQ_NONE;
        req1         = REQ_NONE;
        csr_response = RSP_NONE;
        #12;
        checkOutput("rst_csr_req", csr_request, REQ_NONE);
        checkOutput("rst_grant", grant, 2'b00);
        checkOutput("rst_resp0", resp0, RSP_NONE);
        checkOutput("rst_resp1", resp1, RSP_NONE);
        checkOutput("rst_timeout", timeout_event, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // Constant contention from the first cycle after reset: 0,1,0,1.
        for (int k = 0; k < 4; k++) begin
            writeTx((k % 2 == 0 || k == 0) ? W0 : REQ_NONE,
                    (k % 2 == 1 || k == 0) ? W1 : REQ_NONE,
                    W0, W1, (k % 2 == 0) ? 2'b01 : 2'b10, $sformatf("contend%0d", k));
        end

        // Single write from master 0 with the target acking one cycle after valid.
        applyStimulus(W0, REQ_NONE, RSP_NONE);
        checkOutput("wr_n_grant", grant, 2'b00);
        checkOutput("wr_n_csr_req", csr_request, REQ_NONE);
        applyStimulus(W0, REQ_NONE, RSP_NONE);
        checkOutput("wr_n1_csr_req", csr_request, W0);
        checkOutput("wr_n1_grant", grant, 2'b01);
        applyStimulus(W0, REQ_NONE, RSP_ACK);
        checkOutput("wr_n2_resp0", resp0, RSP_ACK);
        checkOutput("wr_n2_resp1", resp1, RSP_NONE);
        applyStimulus(REQ_NONE, REQ_NONE, RSP_NONE);
        checkOutput("wr_n3_grant", grant, 2'b00);
        checkOutput("wr_n3_csr_req", csr_request, REQ_NONE);
        checkOutput("wr_n3_resp0", resp0, RSP_NONE);

        // Master 0 was served last, so a tie now goes to master 1.
        writeTx(W0, W1, W0, W1, 2'b10, "tiebreak");
        writeTx(W0, REQ_NONE, W0, REQ_NONE, 2'b01, "followup");

        // Master 1 read: ack at cycle 2, data at cycle 5; master 0 waits from cycle 3.
        applyStimulus(REQ_NONE, R1, RSP_NONE);
        checkOutput("rd_c0_grant", grant, 2'b00);
        applyStimulus(REQ_NONE, R1, RSP_NONE);
        checkOutput("rd_c1_grant", grant, 2'b10);
        checkOutput("rd_c1_csr_req", csr_request, R1);
        applyStimulus(REQ_NONE, R1, RSP_ACK);
        checkOutput("rd_c2_resp1", resp1, RSP_ACK);
        applyStimulus(W0, REQ_NONE, RSP_NONE);
        checkOutput("rd_c3_grant", grant, 2'b10);
        checkOutput("rd_c3_valid", csr_request.valid, 1'b0);
        checkOutput("rd_c3_resp1", resp1, RSP_NONE);
        applyStimulus(W0, REQ_NONE, RSP_NONE);
        checkOutput("rd_c4_grant", grant, 2'b10);
        applyStimulus(W0, REQ_NONE, RSP_RDV);
        checkOutput("rd_c5_resp1", resp1, RSP_RDV);
        checkOutput("rd_c5_resp0", resp0, RSP_NONE);
        applyStimulus(W0, REQ_NONE, RSP_NONE);
        checkOutput("rd_c6_grant", grant, 2'b00);
        applyStimulus(W0, REQ_NONE, RSP_NONE);
        checkOutput("rd_c7_grant", grant, 2'b01);
        checkOutput("rd_c7_csr_req", csr_request, W0);
        applyStimulus(W0, REQ_NONE, RSP_ACK);
        checkOutput("rd_c8_resp0", resp0, RSP_ACK);
        applyStimulus(REQ_NONE, REQ_NONE, RSP_NONE);

        // Master 0 read parked in the data phase, then reset with data arriving.
        applyStimulus(R0, REQ_NONE, RSP_NONE);
        applyStimulus(R0, REQ_NONE, RSP_NONE);
        checkOutput("rst_rd_grant", grant, 2'b01);
        applyStimulus(R0, REQ_NONE, RSP_ACK);
        checkOutput("rst_rd_ack", resp0, RSP_ACK);
        applyStimulus(REQ_NONE, REQ_NONE, RSP_NONE);
        checkOutput("rst_rdata_grant", grant, 2'b01);
        @(negedge clk);
        reset_n      = 1'b0;
        csr_response = RSP_RDV;
        #1;
        checkOutput("midrst_csr_req", csr_request, REQ_NONE);
        checkOutput("midrst_grant", grant, 2'b00);
        checkOutput("midrst_resp0", resp0, RSP_NONE);
        checkOutput("midrst_resp1", resp1, RSP_NONE);
        @(negedge clk);
        reset_n      = 1'b1;
        csr_response = RSP_NONE;
        writeTx(W0, W1, W0, W1, 2'b01, "postrst");
        writeTx(REQ_NONE, W1, REQ_NONE, W1, 2'b10, "postrst_m1");
        applyStimulus(REQ_NONE, REQ_NONE, RSP_NONE);

`ifdef CSR_MASTER_ARBITER_TIMEOUT_EN
        // Master 0 read against a silent target; the watchdog fires after 16 cycles.
        applyStimulus(R0, REQ_NONE, RSP_NONE);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(R0, REQ_NONE, RSP_NONE);
            checkOutput($sformatf("tout_wait%0d", i), timeout_event, 1'b0);
        end
        applyStimulus(R0, REQ_NONE, RSP_NONE);
        checkOutput("tout_resp0", resp0, RSP_TOUT);
        checkOutput("tout_event", timeout_event, 1'b1);
        applyStimulus(REQ_NONE, REQ_NONE, RSP_ACK);
        checkOutput("tout_late_event", timeout_event, 1'b0);
        checkOutput("tout_late_resp0", resp0, RSP_NONE);
        checkOutput("tout_late_grant", grant, 2'b00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
